// File: rtl/jk_pkg.sv
// Shared types and the JK next-state rule for jk_stim_sequencer.
// Contents: jk_op_t command encoding, seq_state_t sequencer states,
// and jk_next(), the flop transition used by the reference model.
package jk_pkg;

    localparam int unsigned OP_W = 2;

    // {J,K} command encoding
    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } seq_state_t;

    // JK flop transition: 00 keep, 01 clear, 10 set, 11 invert
    function automatic logic jk_next(input logic q, input jk_op_t op);
        logic q_n;
        case (op)
            OP_HOLD:   q_n = q;
            OP_RESET:  q_n = 1'b0;
            OP_SET:    q_n = 1'b1;
            OP_TOGGLE: q_n = ~q;
            default:   q_n = q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_stim_sequencer_if.sv
// Command handshake bundle for jk_stim_sequencer.
// Signals: cmd_valid (offer), cmd_ready (accept), cmd_op ({J,K} op),
// cmd_cnt (command lasts cmd_cnt+1 cycles).
// master = command source, slave = sequencer.
interface jk_stim_sequencer_if #(
    parameter int unsigned CNT_W = 4
);
    import jk_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [CNT_W-1:0]  cmd_cnt;

    modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);

endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous FIFO holding queued JK commands.
// Ports: clk, rst (sync, active-high), i_push/i_wdata write side,
// i_pop/o_rdata read side (show-ahead), o_full, o_empty.
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
module jk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    // pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // storage, contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/jk_stim_sequencer.sv
// Drives J/K into a JK flop from a queue of {op,count} commands and
// optionally checks the flop's Q/Q_bar against a reference model.
// Ports: clk, rst (sync, active-high); cmd (slave side of
// jk_stim_sequencer_if); J, K to the flop; q_in, q_bar_in from the flop;
// busy, done (last cycle of a command), err (sticky), err_cnt (saturating).
// Build option: define JKSEQ_CHECK_EN to include the model and checker;
// otherwise err/err_cnt are tied to zero and q_in/q_bar_in are ignored.
module jk_stim_sequencer
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_stim_sequencer_if.slave   cmd,
    output logic                 J,
    output logic                 K,
    input  logic                 q_in,
    input  logic                 q_bar_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int unsigned FIFO_W = OP_W + CNT_W;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              r_j;
    logic              r_k;
    logic              r_done;
    logic [CNT_W-1:0]  r_rem;
    logic              w_j_nxt;
    logic              w_k_nxt;
    logic              w_done_nxt;
    logic [CNT_W-1:0]  w_rem_nxt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FIFO_W-1:0] w_rdata;
    logic [OP_W-1:0]   w_head_op;
    logic [CNT_W-1:0]  w_head_cnt;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd.cmd_valid),
        .i_wdata ({cmd.cmd_op, cmd.cmd_cnt}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_op     = w_rdata[CNT_W +: OP_W];
    assign w_head_cnt    = w_rdata[CNT_W-1:0];
    assign cmd.cmd_ready = !w_full;
    assign busy          = !w_empty || (r_state == DRIVE);
    assign J             = r_j;
    assign K             = r_k;
    assign done          = r_done;

    // sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_rem   <= w_rem_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // next state; a new command is popped on the last cycle of the
    // current one so back-to-back commands run without a bubble
    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_rem_nxt   = r_rem;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_j_nxt = 1'b0;
                w_k_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop              = 1'b1;
                    {w_j_nxt, w_k_nxt} = w_head_op;
                    w_rem_nxt          = w_head_cnt;
                    w_state_nxt        = DRIVE;
                end
            end
            DRIVE: begin
                if (r_rem != '0) begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                end else if (!w_empty) begin
                    w_pop              = 1'b1;
                    {w_j_nxt, w_k_nxt} = w_head_op;
                    w_rem_nxt          = w_head_cnt;
                end else begin
                    w_state_nxt = IDLE;
                    w_j_nxt     = 1'b0;
                    w_k_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_j_nxt     = 1'b0;
                w_k_nxt     = 1'b0;
            end
        endcase
        // done lines up with the final driven cycle of a command
        w_done_nxt = (w_state_nxt == DRIVE) && (w_rem_nxt == '0);
    end

`ifdef JKSEQ_CHECK_EN
    logic             r_exp_q;
    logic             r_check_armed;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_mismatch;

    // q_in reflects the model update of the previous edge
    assign w_mismatch = r_check_armed && ((q_in != r_exp_q) || (q_bar_in != ~q_in));

    // reference model tracks the flop on the same edge it samples J/K
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_q       <= 1'b0;
            r_check_armed <= 1'b0;
            r_err         <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_exp_q       <= jk_next(r_exp_q, jk_op_t'({r_j, r_k}));
            r_check_armed <= 1'b1;
            if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_q;

    assign w_unused_q = q_in ^ q_bar_in;
    assign err        = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule
